// File: rtl/buzzer_seq_pkg.sv
// Shared definitions for the buzzer note sequencer: register map, control and
// status bit positions, FSM state encoding and the queued note entry layout.
package buzzer_seq_pkg;

    // Register offsets on the 2-bit IO address
    localparam logic [1:0] REG_NOTE_DATA = 2'd0;
    localparam logic [1:0] REG_NOTE_DUR  = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_STATUS    = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;

    // STATUS read bits
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_FULL     = 1;
    localparam int unsigned STAT_EMPTY    = 2;
    localparam int unsigned STAT_OVERFLOW = 3;
    localparam int unsigned STAT_COUNT_LO = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } seq_state_t;

    // One queued note: tone code in the upper half, duration in ticks below
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] dur;
    } note_entry_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of note entries with flush and a registered head output.
module note_fifo
    import buzzer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  note_entry_t   i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output note_entry_t   o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    note_entry_t   r_mem [DEPTH];
    note_entry_t   r_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;
    logic [AW-1:0] w_rd_nxt;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_head;

    // Flush takes priority over both push and pop
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_rd_nxt  = w_do_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // Entry storage, written at the tail
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= r_count + CW'(w_do_push) - CW'(w_do_pop);
            // New head bypasses storage when the pushed entry lands at the next read slot
            if (w_do_push && (r_wr_ptr == w_rd_nxt)) begin
                r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Memory-mapped note sequencer: queues {tone, duration} notes and plays them
// back-to-back by driving the buzzer's chip-select, write strobe and data.
module buzzer_sequencer
    import buzzer_seq_pkg::*;
#(
    parameter int TICK_DIV   = 25000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        seqCtrl,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [1:0]  address,
    input  logic [15:0] write_data_in,
    output logic [15:0] read_data_out,
    output logic        buzzer_ctrl,
    output logic        buzzer_we,
    output logic [15:0] buzzer_wdata
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;

    logic          r_enable;
    logic          r_overflow;
    logic [15:0]   r_dur_stage;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_remain;
    logic          r_buzzer_ctrl;
    logic          r_buzzer_we;
    logic [15:0]   r_buzzer_wdata;

    logic          w_wr;
    logic          w_ctrl_wr;
    logic          w_push;
    logic          w_flush;
    logic          w_disable;
    logic          w_pop;
    logic          w_play_done;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [2:0]    w_count3;
    note_entry_t   w_head;
    note_entry_t   w_push_entry;
    logic [15:0]   w_status;

    assign w_wr         = seqCtrl && write_enable;
    assign w_ctrl_wr    = w_wr && (address == REG_CTRL);
    assign w_push       = w_wr && (address == REG_NOTE_DATA);
    assign w_flush      = w_ctrl_wr && write_data_in[CTRL_FLUSH];
    assign w_disable    = w_ctrl_wr && !write_data_in[CTRL_ENABLE];
    assign w_push_entry = '{data: write_data_in, dur: r_dur_stage};
    assign w_count3     = 3'(w_count);

    // Final tick of a note ends PLAY in the same cycle remain reaches zero
    assign w_play_done  = (r_remain == '0) ||
                          ((r_remain == 16'd1) && (r_presc == TICK_LAST));

    note_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Register file: staged duration, enable and sticky overflow
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dur_stage <= '0;
            r_enable    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr && (address == REG_NOTE_DUR)) begin
                r_dur_stage <= write_data_in;
            end
            if (w_ctrl_wr) begin
                r_enable <= write_data_in[CTRL_ENABLE];
            end
            if (w_ctrl_wr && write_data_in[CTRL_CLR_OVF]) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full && !w_flush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and FIFO pop
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && !w_empty) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_play_done) begin
                    w_state_nxt = (r_enable && !w_empty) ? ST_LOAD : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A flush or an enable-clearing CTRL write aborts playback at this edge
        if (w_flush || w_disable) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Note timing: prescaler and remaining tick count
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_presc  <= '0;
            r_remain <= '0;
        end else if (r_state == ST_LOAD) begin
            r_presc  <= '0;
            r_remain <= w_head.dur;
        end else if (r_state == ST_PLAY) begin
            if (r_presc == TICK_LAST) begin
                r_presc <= '0;
                if (r_remain != '0) begin
                    r_remain <= r_remain - 16'd1;
                end
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Registered buzzer outputs follow the current state
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_buzzer_ctrl  <= 1'b0;
            r_buzzer_we    <= 1'b0;
            r_buzzer_wdata <= '0;
        end else begin
            r_buzzer_ctrl <= (r_state != ST_IDLE);
            r_buzzer_we   <= (r_state == ST_LOAD);
            if (r_state == ST_LOAD) begin
                r_buzzer_wdata <= w_head.data;
            end
        end
    end

    assign buzzer_ctrl  = r_buzzer_ctrl;
    assign buzzer_we    = r_buzzer_we;
    assign buzzer_wdata = r_buzzer_wdata;

    // STATUS word, driven only during a qualified read
    always_comb begin
        w_status                = '0;
        w_status[STAT_BUSY]     = (r_state != ST_IDLE);
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_OVERFLOW] = r_overflow;
        w_status[STAT_COUNT_LO +: 3] = w_count3;
    end

    assign read_data_out = (seqCtrl && read_enable && (address == REG_STATUS)) ? w_status : '0;

endmodule
